// File: rtl/serial_subtractor_4bit.sv
// Bit-serial two's-complement subtractor: computes a - b - bin one bit per clock, LSB first,
// and reports the unsigned borrow-out and the signed overflow alongside the difference.
module serial_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             br_q,     br_d;
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
  logic             ovf_q,    ovf_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             a_bit_s;
  logic             b_bit_s;
  logic             d_bit_s;
  logic             br_nxt_s;
  logic [WIDTH-1:0] res_shift_s;

  // One-bit full-subtractor slice on the current LSBs of the operand shift registers.
  always_comb begin
    a_bit_s     = a_sh_q[0];
    b_bit_s     = b_sh_q[0];
    d_bit_s     = a_bit_s ^ b_bit_s ^ br_q;
    br_nxt_s    = (~a_bit_s & b_bit_s) | (~(a_bit_s ^ b_bit_s) & br_q);
    res_shift_s = {d_bit_s, res_q[WIDTH-1:1]};
  end

  // Next-state and datapath control for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          br_d    = bin;
          cnt_d   = {CW{1'b0}};
          res_d   = {WIDTH{1'b0}};
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        br_d   = br_nxt_s;
        res_d  = res_shift_s;
        cnt_d  = cnt_q + CNT_ONE;
        // Results are published on the same edge that consumes the last bit.
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_shift_s;
          bout_d  = br_nxt_s;
          ovf_d   = (a_msb_q ^ b_msb_q) & (res_shift_s[WIDTH-1] ^ a_msb_q);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Scoreboard bench for serial_subtractor_4bit: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse and checks timing/holding.
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = 4'd0;
  logic [W-1:0] b     = 4'd0;
  logic         bin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Expected entries are {overflow, bout, diff}.
  logic [5:0] sb[$];
  int         total = 0;
  int         bad   = 0;

  logic       rst_seen  = 1'b0;
  bit         hold_mode = 1'b0;
  bit         end_req   = 1'b0;
  bit         end_done  = 1'b0;
  logic [W-1:0] h_diff  = 4'd0;
  logic       h_bout    = 1'b0;
  logic       h_ovf     = 1'b0;
  int         busy_run  = 0;
  int         gap       = 0;
  bit         have_prev = 1'b0;

  function automatic void chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
    int u;
    int s;
    logic [3:0] d;
    u = int'(x) - int'(y) - int'(c);
    s = int'($signed(x)) - int'($signed(y)) - int'(c);
    d = u[3:0];
    return {(s < -8 || s > 7), (u < 0), d};
  endfunction

  always @(posedge clk) rst_seen <= rst;

  // Monitor: pops the scoreboard on done, checks latency, exclusivity, hold and reset values.
  always @(negedge clk) begin
    logic [5:0] e;
    gap++;
    if (!hold_mode) have_prev = 1'b0;
    if (rst_seen) begin
      h_diff = 4'd0;
      h_bout = 1'b0;
      h_ovf  = 1'b0;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
    end
    chk("busy_done_overlap", int'(busy && done), 0);
    if (done) begin
      chk("busy_cycles", busy_run, W);
      if (hold_mode && have_prev) chk("hold_gap", gap, W + 2);
      gap = 0;
      have_prev = 1'b1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("diff", int'(diff), int'(e[3:0]));
        chk("bout", int'(bout), int'(e[4]));
        chk("overflow", int'(overflow), int'(e[5]));
      end
      h_diff = diff;
      h_bout = bout;
      h_ovf  = overflow;
    end else begin
      chk("hold_diff", int'(diff), int'(h_diff));
      chk("hold_bout", int'(bout), int'(h_bout));
      chk("hold_overflow", int'(overflow), int'(h_ovf));
    end
    if (busy) busy_run++;
    else busy_run = 0;
    if (end_req && !end_done) begin
      chk("queue_empty", sb.size(), 0);
      end_done = 1'b1;
    end
  end

  task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic c,
                       input bit push, input logic [5:0] e);
    @(negedge clk);
    a = x;
    b = y;
    bin = c;
    start = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input logic [3:0] x, input logic [3:0] y, input logic c, input logic [5:0] e);
    issue(x, y, c, 1'b1, e);
    wait_done();
  endtask

  initial begin
    int n;
    int cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, expected {ovf, bout, diff} worked out by hand.
    do_op(4'b0101, 4'b0011, 1'b0, 6'b00_0010);
    do_op(4'b0011, 4'b0101, 1'b0, 6'b01_1110);
    do_op(4'b1000, 4'b0001, 1'b0, 6'b10_0111);
    do_op(4'b0111, 4'b1000, 1'b0, 6'b11_1111);
    do_op(4'b0000, 4'b0000, 1'b1, 6'b01_1111);
    do_op(4'b1000, 4'b0111, 1'b1, 6'b10_0000);

    // Start pulses with new operands while busy and in DONE must be ignored.
    issue(4'b0110, 4'b0010, 1'b0, 1'b1, 6'b00_0100);
    repeat (W) begin
      a = 4'($urandom_range(15, 0));
      b = 4'($urandom_range(15, 0));
      bin = 1'($urandom_range(1, 0));
      start = 1'b1;
      @(negedge clk);
    end
    a = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Start held high: accepted once every W+2 cycles.
    @(negedge clk);
    a = 4'b0101;
    b = 4'b0011;
    bin = 1'b0;
    start = 1'b1;
    hold_mode = 1'b1;
    repeat (3) sb.push_back(6'b00_0010);
    n = 0;
    cnt = 0;
    while (cnt < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (done) cnt++;
    end
    start = 1'b0;
    @(negedge clk);
    hold_mode = 1'b0;

    // Reset during the second SHIFT cycle aborts without a done pulse.
    issue(4'b1010, 4'b0011, 1'b0, 1'b0, 6'b00_0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_op(4'b1111, 4'b0001, 1'b0, 6'b00_1110);

    // Reset and start together: request dropped.
    @(negedge clk);
    rst = 1'b1;
    a = 4'b0001;
    b = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Exhaustive sweep against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 2; k++) begin
          do_op(4'(i), 4'(j), 1'(k), model(4'(i), 4'(j), 1'(k)));
        end
      end
    end

    end_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
